// File: rtl/pwm_multi_generator.sv
// Multi-channel PWM generator with one shared period counter.
// Period and duty values are double-buffered. Pending copies move into the
// active copies at a period boundary, or every cycle while the generator is
// idle, so a pulse is never cut short mid-period.
module pwm_multi_generator #(
    parameter int CH  = 4,
    parameter int W   = 12,
    localparam int CSW = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_en,
    input  logic [1:0]     reg_sel,
    input  logic [CSW-1:0] ch_sel,
    input  logic [W-1:0]   wdata,
    output logic [CH-1:0]  pwm_out,
    output logic           period_tick,
    output logic           busy
);

    localparam logic [1:0] SEL_PERIOD = 2'd0;
    localparam logic [1:0] SEL_DUTY   = 2'd1;
    localparam logic [1:0] SEL_EN     = 2'd2;
    localparam logic [1:0] SEL_POL    = 2'd3;

    logic [W-1:0]         r_period_pend;
    logic [W-1:0]         r_period_act;
    logic [CH-1:0][W-1:0] r_duty_pend;
    logic [CH-1:0][W-1:0] r_duty_act;
    logic                 r_en;
    logic [CH-1:0]        r_pol;
    logic [W-1:0]         r_cnt;
    logic [CH-1:0]        r_pwm;
    logic                 r_tick;

    logic                 w_run;
    logic [W-1:0]         w_pm1;
    logic                 w_last;
    logic                 w_load;
    logic [4:0]           w_ch_ext;
    logic                 w_ch_ok;
    logic [CH-1:0]        w_hit;

    // Running only with a non-zero period; period-1 is never formed from zero
    assign w_run    = r_en & (r_period_act != '0);
    assign w_pm1    = (r_period_act != '0) ? (r_period_act - 1'b1) : '0;
    assign w_last   = w_run & (r_cnt == w_pm1);
    assign w_load   = w_last | ~w_run;

    // Channel indices that do not map to a real channel drop the write
    assign w_ch_ext = 5'(ch_sel);
    assign w_ch_ok  = (w_ch_ext < 5'(CH));

    // Per-channel active window: true while the count is below the duty
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < CH; i++) begin
            w_hit[i] = (r_cnt < r_duty_act[i]);
        end
    end

    // Shared period counter; held at zero while idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!w_run || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Shadow load of all active values at once, from the pre-edge pending copies
    always_ff @(posedge clk) begin
        if (rst) begin
            r_period_act <= '0;
            r_duty_act   <= '0;
        end else if (w_load) begin
            r_period_act <= r_period_pend;
            r_duty_act   <= r_duty_pend;
        end
    end

    // Register writes: period/duty to pending, enable/polarity take effect directly
    always_ff @(posedge clk) begin
        if (rst) begin
            r_period_pend <= '0;
            r_duty_pend   <= '0;
            r_en          <= 1'b0;
            r_pol         <= '0;
        end else if (wr_en) begin
            case (reg_sel)
                SEL_PERIOD: r_period_pend <= wdata;
                SEL_DUTY:   if (w_ch_ok) r_duty_pend[ch_sel] <= wdata;
                SEL_EN:     r_en <= wdata[0];
                SEL_POL:    if (w_ch_ok) r_pol[ch_sel] <= wdata[0];
                default:    ;
            endcase
        end
    end

    // Registered outputs, one cycle behind the counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_pwm  <= w_run ? (w_hit ^ r_pol) : r_pol;
            r_tick <= w_run & (r_cnt == '0);
        end
    end

    assign pwm_out     = r_pwm;
    assign period_tick = r_tick;
    assign busy        = (r_period_pend != r_period_act) | (r_duty_pend != r_duty_act);

endmodule

// File: tb/tb_pwm_multi_generator.sv
// Scoreboard bench for pwm_multi_generator: a behavioural model predicts
// every cycle's outputs, a separate monitor compares them after each edge.
module tb_pwm_multi_generator;

    localparam int CH  = 4;
    localparam int W   = 12;
    localparam int CSW = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           wr_en = 1'b0;
    logic [1:0]     reg_sel = 2'd0;
    logic [CSW-1:0] ch_sel = '0;
    logic [W-1:0]   wdata = '0;
    logic [CH-1:0]  pwm_out;
    logic           period_tick;
    logic           busy;

    int n_test = 0;
    int n_fail = 0;

    pwm_multi_generator #(.CH(CH), .W(W)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .reg_sel(reg_sel), .ch_sel(ch_sel),
        .wdata(wdata), .pwm_out(pwm_out), .period_tick(period_tick), .busy(busy)
    );

    always #5 clk = ~clk;

    // Expected {busy, tick, pwm} after each edge
    logic [CH+1:0] exp_q[$];

    // Behavioural model: period/duty settings, position inside the period
    int m_per_pend, m_per_act;
    int m_duty_pend[CH];
    int m_duty_act[CH];
    bit m_en;
    bit m_pol[CH];
    int m_pos;

    task automatic model_edge(input bit r, input bit we, input int sel, input int ch, input int d);
        logic [CH-1:0] e_pwm;
        bit e_tick, e_busy, running, at_end;
        e_pwm = '0;
        e_tick = 0;
        e_busy = 0;
        if (r) begin
            m_per_pend = 0; m_per_act = 0; m_en = 0; m_pos = 0;
            for (int i = 0; i < CH; i++) begin
                m_duty_pend[i] = 0; m_duty_act[i] = 0; m_pol[i] = 0;
            end
        end else begin
            running = m_en && (m_per_act > 0);
            for (int i = 0; i < CH; i++) begin
                if (running) e_pwm[i] = (m_pos < m_duty_act[i]) != m_pol[i];
                else         e_pwm[i] = m_pol[i];
            end
            e_tick = running && (m_pos == 0);
            at_end = running && (m_pos == m_per_act - 1);
            if (running && !at_end) m_pos = m_pos + 1;
            else                    m_pos = 0;
            if (at_end || !running) begin
                m_per_act = m_per_pend;
                for (int i = 0; i < CH; i++) m_duty_act[i] = m_duty_pend[i];
            end
            if (we) begin
                if (sel == 0)                m_per_pend = d;
                else if (sel == 1 && ch < CH) m_duty_pend[ch] = d;
                else if (sel == 2)           m_en = d[0];
                else if (sel == 3 && ch < CH) m_pol[ch] = d[0];
            end
            e_busy = (m_per_pend != m_per_act);
            for (int i = 0; i < CH; i++)
                if (m_duty_pend[i] != m_duty_act[i]) e_busy = 1;
        end
        exp_q.push_back({e_busy, e_tick, e_pwm});
    endtask

    // One clock cycle of stimulus, driven away from the active edge
    task automatic cyc(input bit r, input bit we, input int sel, input int ch, input int d);
        @(negedge clk);
        rst     = r;
        wr_en   = we;
        reg_sel = 2'(sel);
        ch_sel  = CSW'(ch);
        wdata   = W'(d);
        model_edge(r, we, sel, ch, d);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic wr(input int sel, input int ch, input int d);
        cyc(0, 1, sel, ch, d);
    endtask

    task automatic wait_pos(input int p);
        int guard;
        guard = 0;
        while (m_pos != p && guard < 64) begin
            idle(1);
            guard++;
        end
        n_test++;
        if (m_pos != p) begin
            n_fail++;
            $display("FAIL wait_pos pos=%0d required=%0d", m_pos, p);
        end
    endtask

    // Monitor: compare DUT outputs with the oldest prediction after every edge
    always @(posedge clk) begin
        logic [CH+1:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_test++;
            if ({busy, period_tick, pwm_out} !== e) begin
                n_fail++;
                $display("FAIL sb_out t=%0t got busy=%b tick=%b pwm=%b required busy=%b tick=%b pwm=%b",
                         $time, busy, period_tick, pwm_out, e[CH+1], e[CH], e[CH-1:0]);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int sel, d;
        idle(0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);

        // Basic run: period 10, duty 3
        wr(0, 0, 10);
        wr(1, 0, 3);
        wr(2, 0, 1);
        idle(25);

        // Duty change mid-period lands at the next boundary
        wait_pos(2);
        wr(1, 0, 7);
        idle(25);

        // Duty extremes: zero, equal to period, above period
        wr(1, 1, 0);
        wr(1, 2, 10);
        wr(1, 3, 15);
        idle(25);

        // Inverted polarity, then disable
        wr(1, 0, 3);
        wr(3, 0, 1);
        idle(25);
        wr(2, 0, 0);
        idle(6);

        // Zero period while running
        wr(2, 0, 1);
        idle(4);
        wr(0, 0, 0);
        idle(22);

        // Reset mid-period, then restart with enable rewritten
        wr(0, 0, 10);
        idle(12);
        wait_pos(5);
        cyc(1, 1, 2, 0, 1);
        idle(5);
        wr(0, 0, 10);
        wr(1, 0, 4);
        wr(2, 0, 1);
        idle(15);

        // Randomized writes and occasional resets
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 299) == 0) begin
                cyc(1, 0, 0, 0, 0);
            end else if ($urandom_range(0, 3) == 0) begin
                sel = int'($urandom_range(0, 3));
                case (sel)
                    0:       d = int'($urandom_range(0, 16));
                    1:       d = int'($urandom_range(0, 20));
                    2:       d = ($urandom_range(0, 4) != 0) ? 1 : 0;
                    default: d = int'($urandom_range(0, 1));
                endcase
                wr(sel, int'($urandom_range(0, CH - 1)), d);
            end else begin
                idle(1);
            end
        end

        idle(2);
        @(posedge clk);
        #3;
        n_test++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain left=%0d required=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
        $finish;
    end

endmodule
